// File: rtl/adsr_envelope.sv
// ADSR envelope generator: advances one step per rising edge of sample_clk, all in the clk_in domain.
// Latency: env_out/state_out/env_valid update on the clk_in edge where the step is detected; no backpressure.
module adsr_envelope #(
   parameter int ENV_WIDTH  = 16,
   parameter int RATE_WIDTH = 16
) (
   input  logic                  clk_in,
   input  logic                  reset,
   input  logic                  sample_clk,
   input  logic                  gate,
   input  logic [RATE_WIDTH-1:0] attack_rate,
   input  logic [RATE_WIDTH-1:0] decay_rate,
   input  logic [ENV_WIDTH-1:0]  sustain_level,
   input  logic [RATE_WIDTH-1:0] release_rate,
   output logic [ENV_WIDTH-1:0]  env_out,
   output logic                  env_valid,
   output logic [2:0]            state_out,
   output logic                  busy
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ATTACK  = 3'd1,
      S_DECAY   = 3'd2,
      S_SUSTAIN = 3'd3,
      S_RELEASE = 3'd4
   } state_t;

   localparam logic [ENV_WIDTH-1:0] MAX     = '1;
   localparam logic [ENV_WIDTH:0]   MAX_EXT = {1'b0, MAX};
   localparam int                   PAD     = ENV_WIDTH + 1 - RATE_WIDTH;

   state_t                state_q;
   logic [ENV_WIDTH-1:0]  env_q;
   logic                  valid_q;
   logic                  sample_prev_q;
   logic                  gate_q;

   logic                  step;
   logic                  gate_rise;
   logic [ENV_WIDTH:0]    env_ext;
   logic [ENV_WIDTH:0]    atk_ext;
   logic [ENV_WIDTH:0]    dec_ext;
   logic [ENV_WIDTH:0]    rel_ext;
   logic [ENV_WIDTH:0]    att_sum;
   logic [ENV_WIDTH:0]    dec_diff;
   logic [ENV_WIDTH:0]    rel_diff;
   logic                  att_sat;
   logic                  dec_done;
   logic                  rel_done;
   logic [ENV_WIDTH-1:0]  att_env_d;
   logic [ENV_WIDTH-1:0]  rel_env_d;

   assign step      = sample_clk & ~sample_prev_q;
   assign gate_rise = gate & ~gate_q;

   assign env_ext = {1'b0, env_q};
   assign atk_ext = {{PAD{1'b0}}, attack_rate};
   assign dec_ext = {{PAD{1'b0}}, decay_rate};
   assign rel_ext = {{PAD{1'b0}}, release_rate};

   // Differences borrow into the top bit when the rate exceeds the level.
   assign att_sum  = env_ext + atk_ext;
   assign dec_diff = env_ext - dec_ext;
   assign rel_diff = env_ext - rel_ext;

   assign att_sat  = (att_sum >= MAX_EXT) || (attack_rate == '0);
   assign dec_done = dec_diff[ENV_WIDTH] || (dec_diff <= {1'b0, sustain_level})
                     || (decay_rate == '0);
   assign rel_done = rel_diff[ENV_WIDTH] || (rel_diff == '0) || (release_rate == '0);

   assign att_env_d = att_sat  ? MAX : att_sum[ENV_WIDTH-1:0];
   assign rel_env_d = rel_done ? '0  : rel_diff[ENV_WIDTH-1:0];

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         env_q         <= '0;
         valid_q       <= 1'b0;
         sample_prev_q <= 1'b0;
         gate_q        <= 1'b0;
      end else begin
         sample_prev_q <= sample_clk;
         valid_q       <= step;
         if (step) begin
            gate_q <= gate;
            if (gate_rise) begin
               env_q   <= att_env_d;
               state_q <= att_sat ? S_DECAY : S_ATTACK;
            end else if (!gate && (state_q == S_ATTACK || state_q == S_DECAY ||
                                   state_q == S_SUSTAIN)) begin
               env_q   <= rel_env_d;
               state_q <= rel_done ? S_IDLE : S_RELEASE;
            end else begin
               case (state_q)
                  S_IDLE: begin
                     env_q <= '0;
                  end
                  S_ATTACK: begin
                     env_q   <= att_env_d;
                     state_q <= att_sat ? S_DECAY : S_ATTACK;
                  end
                  S_DECAY: begin
                     env_q   <= dec_done ? sustain_level : dec_diff[ENV_WIDTH-1:0];
                     state_q <= dec_done ? S_SUSTAIN : S_DECAY;
                  end
                  S_SUSTAIN: begin
                     env_q <= sustain_level;
                  end
                  S_RELEASE: begin
                     env_q   <= rel_env_d;
                     state_q <= rel_done ? S_IDLE : S_RELEASE;
                  end
                  default: begin
                     env_q   <= '0;
                     state_q <= S_IDLE;
                  end
               endcase
            end
         end
      end
   end

   assign env_out   = env_q;
   assign env_valid = valid_q;
   assign state_out = state_q;
   assign busy      = (state_q != S_IDLE);

endmodule
